// File: rtl/pe_array_mc.sv
// Weight-stationary ROWS x COLS MAC array fed by tagged multicast activation and weight buses,
// with a drain FSM that reduces each column, adds psum_in and presents registered psums.
module pe_array_mc #(
    parameter int ROWS   = 12,
    parameter int COLS   = 14,
    parameter int DATA_W = 16,
    parameter int PSUM_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      act_data,
    input  logic [TAG_W-1:0]       act_row_tag,
    input  logic [TAG_W-1:0]       act_col_tag,
    input  logic                   act_valid,
    output logic                   act_ready,
    input  logic [DATA_W-1:0]      w_data,
    input  logic [TAG_W-1:0]       w_row_tag,
    input  logic [TAG_W-1:0]       w_col_tag,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic                   w_clear,
    input  logic                   drain_start,
    input  logic [COLS*PSUM_W-1:0] psum_in,
    output logic [COLS*PSUM_W-1:0] psum_out,
    output logic                   psum_valid,
    output logic                   busy
);

    localparam logic [TAG_W-1:0] TAG_ALL = '1;
    localparam int               PROD_W  = 2 * DATA_W;
    localparam int               K_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [K_W-1:0]   K_LAST  = K_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [K_W-1:0] k;

    logic signed [DATA_W-1:0] act_q   [ROWS][COLS];
    logic signed [DATA_W-1:0] w_q     [ROWS][COLS];
    logic                     act_v   [ROWS][COLS];
    logic                     w_v     [ROWS][COLS];
    logic signed [PSUM_W-1:0] acc     [ROWS][COLS];
    logic signed [PSUM_W-1:0] col_sum [COLS];

    logic                     act_hit [ROWS][COLS];
    logic                     w_hit   [ROWS][COLS];
    logic                     mac_en  [ROWS][COLS];
    logic signed [PROD_W-1:0] prod    [ROWS][COLS];

    logic idle;
    logic act_block;
    logic act_fire;
    logic w_fire;

    // A tag selects one index or, when all-ones, every index; out-of-range tags select nothing.
    function automatic logic tag_match(input logic [TAG_W-1:0] tag, input int idx);
        return (tag == TAG_ALL) || (int'(tag) == idx);
    endfunction

    assign idle      = (state == IDLE);
    assign act_ready = idle && !act_block;
    assign w_ready   = idle;
    assign busy      = !idle;
    assign act_fire  = act_valid && act_ready;
    assign w_fire    = w_valid && w_ready;

    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        act_block = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                act_hit[r][c] = tag_match(act_row_tag, r) && tag_match(act_col_tag, c);
                w_hit[r][c]   = tag_match(w_row_tag, r) && tag_match(w_col_tag, c);
                mac_en[r][c]  = idle && act_v[r][c] && w_v[r][c];
                prod[r][c]    = PROD_W'(act_q[r][c]) * PROD_W'(w_q[r][c]);
                // A target still waiting for its weight cannot take another activation.
                if (act_hit[r][c] && act_v[r][c] && !w_v[r][c]) begin
                    act_block = 1'b1;
                end
            end
        end
    end

    // NOTE: the operand registers carry no reset; they are only consumed when their valid bit is set,
    // which keeps the reset net off the wide data storage.
    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (act_fire && act_hit[r][c]) begin
                    act_q[r][c] <= act_data;
                end
                if (w_fire && w_hit[r][c]) begin
                    w_q[r][c] <= w_data;
                end
            end
        end
    end

    // NOTE: state uses non-blocking assignments so a MAC and a same-edge reload both see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    act_v[r][c] <= 1'b0;
                    w_v[r][c]   <= 1'b0;
                    acc[r][c]   <= '0;
                end
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (mac_en[r][c]) begin
                        acc[r][c] <= acc[r][c] + PSUM_W'(prod[r][c]);
                    end else if (state == DONE) begin
                        acc[r][c] <= '0;
                    end

                    if (act_fire && act_hit[r][c]) begin
                        act_v[r][c] <= 1'b1;
                    end else if (mac_en[r][c]) begin
                        act_v[r][c] <= 1'b0;
                    end

                    if (w_fire && w_hit[r][c]) begin
                        w_v[r][c] <= 1'b1;
                    end else if (w_clear) begin
                        w_v[r][c] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (drain_start) state_next = DRAIN;
            DRAIN:   if (k == K_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Row k of every column is folded into col_sum each DRAIN cycle; DONE publishes and clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k          <= '0;
            psum_out   <= '0;
            psum_valid <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
                col_sum[c] <= '0;
            end
        end else begin
            psum_valid <= (state == DONE);
            case (state)
                IDLE: begin
                    if (drain_start) begin
                        k <= '0;
                        for (int c = 0; c < COLS; c++) begin
                            col_sum[c] <= '0;
                        end
                    end
                end
                DRAIN: begin
                    for (int c = 0; c < COLS; c++) begin
                        col_sum[c] <= col_sum[c] + acc[k][c];
                    end
                    if (k != K_LAST) begin
                        k <= k + K_W'(1);
                    end
                end
                DONE: begin
                    for (int c = 0; c < COLS; c++) begin
                        psum_out[c*PSUM_W +: PSUM_W] <= psum_in[c*PSUM_W +: PSUM_W] + col_sum[c];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_array_mc.sv
// Directed self-checking bench for pe_array_mc at default parameters (12x14, 16-bit data, 32-bit psum).
module tb_pe_array_mc;

    localparam int ROWS   = 12;
    localparam int COLS   = 14;
    localparam int DATA_W = 16;
    localparam int PSUM_W = 32;
    localparam int TAG_W  = 4;
    localparam int VW     = COLS * PSUM_W;
    localparam logic [TAG_W-1:0] ALL = '1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] act_data = '0;
    logic [TAG_W-1:0]  act_row_tag = '0;
    logic [TAG_W-1:0]  act_col_tag = '0;
    logic              act_valid = 1'b0;
    logic              act_ready;
    logic [DATA_W-1:0] w_data = '0;
    logic [TAG_W-1:0]  w_row_tag = '0;
    logic [TAG_W-1:0]  w_col_tag = '0;
    logic              w_valid = 1'b0;
    logic              w_ready;
    logic              w_clear = 1'b0;
    logic              drain_start = 1'b0;
    logic [VW-1:0]     psum_in = '0;
    logic [VW-1:0]     psum_out;
    logic              psum_valid;
    logic              busy;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    pe_array_mc #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .PSUM_W(PSUM_W), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst(rst),
        .act_data(act_data), .act_row_tag(act_row_tag), .act_col_tag(act_col_tag),
        .act_valid(act_valid), .act_ready(act_ready),
        .w_data(w_data), .w_row_tag(w_row_tag), .w_col_tag(w_col_tag),
        .w_valid(w_valid), .w_ready(w_ready),
        .w_clear(w_clear), .drain_start(drain_start),
        .psum_in(psum_in), .psum_out(psum_out), .psum_valid(psum_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] one_col(input int c, input logic [PSUM_W-1:0] v);
        logic [VW-1:0] x;
        x = '0;
        x[c*PSUM_W +: PSUM_W] = v;
        return x;
    endfunction

    // Handshake tasks start and end at a falling edge and hold valid until accepted.
    task automatic send_act(input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] rt, input logic [TAG_W-1:0] ct);
        int n;
        act_data = d; act_row_tag = rt; act_col_tag = ct; act_valid = 1'b1;
        n = 0;
        while (!act_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++; failed++;
            $error("FAIL act_handshake_timeout: observed act_ready=0 for %0d cycles expected 1", n);
        end
        @(negedge clk);
        act_valid = 1'b0;
    endtask

    task automatic send_w(input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] rt, input logic [TAG_W-1:0] ct);
        int n;
        w_data = d; w_row_tag = rt; w_col_tag = ct; w_valid = 1'b1;
        n = 0;
        while (!w_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++; failed++;
            $error("FAIL w_handshake_timeout: observed w_ready=0 for %0d cycles expected 1", n);
        end
        @(negedge clk);
        w_valid = 1'b0;
    endtask

    task automatic pulse_w_clear();
        w_clear = 1'b1;
        @(negedge clk);
        w_clear = 1'b0;
    endtask

    // drain_start sampled at edge 0; psum_valid must rise exactly after edge ROWS+1 for one cycle.
    task automatic run_drain(input string tag);
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        check({tag, "_busy"}, VW'(busy), VW'(1));
        repeat (ROWS) @(negedge clk);
        check({tag, "_valid_early"}, VW'(psum_valid), VW'(0));
        @(negedge clk);
        check({tag, "_valid"}, VW'(psum_valid), VW'(1));
        check({tag, "_idle"}, VW'(busy), VW'(0));
        @(negedge clk);
        check({tag, "_valid_pulse"}, VW'(psum_valid), VW'(0));
    endtask

    initial begin
        logic [VW-1:0] exp;
        int pulses;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_psum_out", psum_out, '0);
        check("rst_psum_valid", VW'(psum_valid), VW'(0));
        check("rst_busy", VW'(busy), VW'(0));
        check("rst_act_ready", VW'(act_ready), VW'(1));
        check("rst_w_ready", VW'(w_ready), VW'(1));
        rst = 1'b1;
        @(negedge clk);

        // Single PE: 4*10 lands in column 5 only
        send_act(16'd4, 4'd3, 4'd5);
        send_w(16'd10, 4'd3, 4'd5);
        repeat (2) @(negedge clk);
        psum_in = '0;
        run_drain("single");
        check("single_psum", psum_out, one_col(5, 32'd40));

        // Broadcast: every PE computes 2*3, each column sums ROWS of them plus psum_in[c]=c
        send_w(16'd3, ALL, ALL);
        send_act(16'd2, ALL, ALL);
        repeat (2) @(negedge clk);
        for (int c = 0; c < COLS; c++) psum_in[c*PSUM_W +: PSUM_W] = PSUM_W'(c);
        run_drain("bcast");
        exp = '0;
        for (int c = 0; c < COLS; c++) exp[c*PSUM_W +: PSUM_W] = PSUM_W'(6 * ROWS + c);
        check("bcast_psum", psum_out, exp);
        psum_in = '0;
        run_drain("bcast_clear");
        check("bcast_clear_psum", psum_out, '0);

        // Signed product: -5 * 7 = -35
        pulse_w_clear();
        send_w(16'hFFFB, 4'd0, 4'd0);
        send_act(16'd7, 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        run_drain("signed");
        check("signed_psum", psum_out, one_col(0, 32'hFFFF_FFDD));

        // Wrap: two (-32768)^2 products give 2^31 -> 0x80000000, plus psum_in 0x7FFFFFFF -> 0xFFFFFFFF
        send_w(16'h8000, 4'd1, 4'd1);
        send_act(16'h8000, 4'd1, 4'd1);
        send_act(16'h8000, 4'd1, 4'd1);
        repeat (2) @(negedge clk);
        psum_in = one_col(1, 32'h7FFF_FFFF);
        run_drain("wrap");
        check("wrap_psum", psum_out, one_col(1, 32'hFFFF_FFFF));
        psum_in = '0;

        // Backpressure: an act waiting on a missing weight blocks further acts to that PE only
        pulse_w_clear();
        send_act(16'd1, 4'd2, 4'd2);
        act_data = 16'd1; act_row_tag = 4'd2; act_col_tag = 4'd3;
        #1 check("bp_other_pe_ready", VW'(act_ready), VW'(1));
        act_col_tag = 4'd2;
        #1 check("bp_blocked", VW'(act_ready), VW'(0));
        act_row_tag = ALL; act_col_tag = ALL;
        #1 check("bp_blocked_bcast", VW'(act_ready), VW'(0));
        act_row_tag = 4'd2; act_col_tag = 4'd2; act_valid = 1'b1;
        w_data = 16'd9; w_row_tag = 4'd2; w_col_tag = 4'd2; w_valid = 1'b1;
        @(negedge clk);
        w_valid = 1'b0;
        check("bp_unblocked", VW'(act_ready), VW'(1));
        @(negedge clk);
        act_valid = 1'b0;
        repeat (2) @(negedge clk);
        run_drain("bp");
        check("bp_psum", psum_out, one_col(2, 32'd18));

        // Drain exclusivity: act accepted on the drain_start edge stays pending through the drain
        act_data = 16'd7; act_row_tag = 4'd2; act_col_tag = 4'd2; act_valid = 1'b1;
        drain_start = 1'b1;
        @(negedge clk);
        act_valid = 1'b0;
        drain_start = 1'b0;
        check("excl_busy", VW'(busy), VW'(1));
        check("excl_act_ready", VW'(act_ready), VW'(0));
        check("excl_w_ready", VW'(w_ready), VW'(0));
        pulses = 0;
        for (int i = 0; i < ROWS + 6; i++) begin
            drain_start = (i == 3);
            @(negedge clk);
            if (psum_valid) pulses++;
        end
        drain_start = 1'b0;
        check("excl_pulses", VW'(pulses), VW'(1));
        check("excl_psum", psum_out, '0);
        run_drain("pending");
        check("pending_psum", psum_out, one_col(2, 32'd63));

        // Reset mid-drain at k=5
        send_act(16'd3, 4'd2, 4'd2);
        repeat (2) @(negedge clk);
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", VW'(busy), VW'(0));
        check("mid_rst_psum_out", psum_out, '0);
        check("mid_rst_psum_valid", VW'(psum_valid), VW'(0));
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < ROWS + 4; i++) begin
            @(negedge clk);
            if (psum_valid) pulses++;
        end
        check("mid_rst_no_pulse", VW'(pulses), VW'(0));
        run_drain("post_rst");
        check("post_rst_psum", psum_out, '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
